triple_sequence_checker: RTL and testbench

- Receive-side checker/decoder for the repeated-symbol counter stream 0,0,0,1,1,1,2,2,2,3,3,3,0,…, where each value appears REPEAT times and values step by +1 mod 2^WIDTH.
- Aligns to the run phase, recovers one decoded value per completed run, declares lock after LOCK_RUNS good runs, and flags any deviation.
- Sits at the consuming end of a link driven by the team's repeated-symbol counter.

---
 rtl/triple_sequence_checker_if.sv | 45 ++++
 rtl/triple_sequence_checker.sv | 177 +++++++++++++++++
 tb/tb_triple_sequence_checker.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/triple_sequence_checker_if.sv
// Purpose: bundles the symbol stream input and the decoded/status outputs of triple_sequence_checker.
// Latency: none (signal bundle only).
// Backpressure: none; the source qualifies each symbol with in_valid and the checker always accepts it.
//
// Signals:
//   in_valid   - source qualifies in_data this cycle
//   in_data    - incoming symbol, WIDTH bits
//   run_done   - one-cycle pulse, a full run of identical symbols completed
//   run_value  - value of the last completed run, held between pulses
//   locked     - checker is in its locked state
//   err        - one-cycle pulse on a sequence violation
//   err_count  - saturating count of err pulses since reset
interface triple_sequence_checker_if #(
    parameter int WIDTH = 2
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             run_done;
    logic [WIDTH-1:0] run_value;
    logic             locked;
    logic             err;
    logic [7:0]       err_count;

    // master: the symbol source / observer side
    modport master (
        output in_valid,
        output in_data,
        input  run_done,
        input  run_value,
        input  locked,
        input  err,
        input  err_count
    );

    // slave: the checker itself
    modport slave (
        input  in_valid,
        input  in_data,
        output run_done,
        output run_value,
        output locked,
        output err,
        output err_count
    );
endinterface

// File: rtl/triple_sequence_checker.sv
// Purpose: receive-side checker for the repeated-symbol counter stream (each value REPEAT times, +1 mod 2^WIDTH).
// Latency: one cycle; every output reflects the sample accepted on the preceding clk edge.
// Backpressure: none; every in_valid sample is consumed, in_valid low freezes all state.
//
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   bus (slave)      - in_valid/in_data in; run_done/run_value/locked/err/err_count out
//
// Operation: HUNT waits for any +1 transition between consecutive samples and takes it as
// the start of a run. SYNC and LOCKED then demand exactly REPEAT copies of each value
// followed by a +1 step. LOCK_RUNS completed runs in SYNC promote to LOCKED; any deviation
// in SYNC or LOCKED pulses err and falls back to HUNT.
module triple_sequence_checker #(
    parameter int WIDTH     = 2,
    parameter int REPEAT    = 3,
    parameter int LOCK_RUNS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    triple_sequence_checker_if.slave  bus
);

    // rep counts 1..REPEAT, good_runs counts 0..LOCK_RUNS
    localparam int REP_W = $clog2(REPEAT + 1);
    localparam int GR_W  = $clog2(LOCK_RUNS + 1);

    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
    localparam logic [REP_W-1:0] REP_FULL = REP_W'(REPEAT);
    localparam logic [GR_W-1:0]  GR_ONE   = GR_W'(1);
    localparam logic [GR_W-1:0]  GR_LOCK  = GR_W'(LOCK_RUNS);
    localparam logic [7:0]       ERR_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_t             state_q,     state_d;
    logic               have_prev_q, have_prev_d;
    logic [WIDTH-1:0]   prev_q,      prev_d;
    logic [WIDTH-1:0]   cur_q,       cur_d;
    logic [REP_W-1:0]   rep_q,       rep_d;
    logic [GR_W-1:0]    good_q,      good_d;

    // Registered outputs
    logic               run_done_q,  run_done_d;
    logic [WIDTH-1:0]   run_value_q, run_value_d;
    logic               locked_q;
    logic               err_q,       err_d;
    logic [7:0]         err_count_q, err_count_d;

    // Successor values; the adds wrap naturally at WIDTH bits, so 2^WIDTH-1 -> 0
    // is treated as an ordinary +1 step.
    logic [WIDTH-1:0]   prev_inc;
    logic [WIDTH-1:0]   cur_inc;
    logic [REP_W-1:0]   rep_inc;
    logic [GR_W-1:0]    good_inc;

    assign prev_inc = prev_q + WIDTH'(1);
    assign cur_inc  = cur_q  + WIDTH'(1);
    assign rep_inc  = rep_q  + REP_ONE;
    assign good_inc = good_q + GR_ONE;

    // ---------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        rep_d       = rep_q;
        good_d      = good_q;
        run_done_d  = 1'b0;
        run_value_d = run_value_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;

        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (!have_prev_q) begin
                        prev_d      = bus.in_data;
                        have_prev_d = 1'b1;
                    end else if (bus.in_data == prev_inc) begin
                        // A +1 transition marks the first symbol of a fresh run.
                        cur_d   = bus.in_data;
                        rep_d   = REP_ONE;
                        good_d  = '0;
                        state_d = SYNC;
                    end else begin
                        prev_d  = bus.in_data;
                    end
                end

                SYNC, LOCKED: begin
                    if ((rep_q < REP_FULL) && (bus.in_data == cur_q)) begin
                        rep_d = rep_inc;
                        if (rep_inc == REP_FULL) begin
                            run_done_d  = 1'b1;
                            run_value_d = cur_q;
                            if (state_q == SYNC) begin
                                good_d = good_inc;
                                if (good_inc == GR_LOCK) begin
                                    state_d = LOCKED;
                                end
                            end
                        end
                    end else if ((rep_q == REP_FULL) && (bus.in_data == cur_inc)) begin
                        cur_d = bus.in_data;
                        rep_d = REP_ONE;
                    end else begin
                        // Short run, long run or wrong step: restart the hunt from
                        // this sample so a +1 on the next one can re-sync immediately.
                        err_d       = 1'b1;
                        err_count_d = (err_count_q == ERR_MAX) ? err_count_q
                                                               : err_count_q + 8'd1;
                        state_d     = HUNT;
                        prev_d      = bus.in_data;
                        have_prev_d = 1'b1;
                        good_d      = '0;
                    end
                end

                default: begin
                    // Unused encoding: fall back to a clean hunt.
                    state_d     = HUNT;
                    have_prev_d = 1'b0;
                    good_d      = '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            cur_q       <= '0;
            rep_q       <= '0;
            good_q      <= '0;
            run_done_q  <= 1'b0;
            run_value_q <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            rep_q       <= rep_d;
            good_q      <= good_d;
            run_done_q  <= run_done_d;
            run_value_q <= run_value_d;
            // Tracks the next state so locked moves on the same edge as the FSM.
            locked_q    <= (state_d == LOCKED);
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.run_done  = run_done_q;
    assign bus.run_value = run_value_q;
    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_triple_sequence_checker.sv
module tb_triple_sequence_checker;

    logic clk = 1'b0;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    triple_sequence_checker_if #(.WIDTH(2)) bus ();

    triple_sequence_checker #(
        .WIDTH     (2),
        .REPEAT    (3),
        .LOCK_RUNS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clean acquisition from reset: 0,0,0,1,1,1,2,2,2,3,3,3,0,0,0
    localparam logic [1:0] CL_DIN [15] = '{0,0,0,1,1,1,2,2,2,3,3,3,0,0,0};
    localparam bit         CL_ED  [15] = '{0,0,0,0,0,1,0,0,1,0,0,1,0,0,1};
    localparam logic [1:0] CL_EV  [15] = '{0,0,0,0,0,1,1,1,2,2,2,3,3,3,0};
    localparam bit         CL_EL  [15] = '{0,0,0,0,0,0,0,0,1,1,1,1,1,1,1};
    // Idle cycles inserted after each sample of the clean sequence
    localparam int         GAP    [15] = '{1,0,3,0,2,4,0,1,2,0,0,3,1,0,0};

    // Lock, short run 3,3,0, then re-lock with 0,0,1,1,1,2,2,2
    localparam logic [1:0] SH_DIN [18] = '{0,1,1,1,2,2,2,3,3,0,0,0,1,1,1,2,2,2};
    localparam bit         SH_ED  [18] = '{0,0,0,1,0,0,1,0,0,0,0,0,0,0,1,0,0,1};
    localparam logic [1:0] SH_EV  [18] = '{0,0,0,1,1,1,2,2,2,2,2,2,2,2,1,1,1,2};
    localparam bit         SH_EL  [18] = '{0,0,0,0,0,0,1,1,1,0,0,0,0,0,0,0,0,1};
    localparam bit         SH_EE  [18] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0};

    // From locked on value 2: run of 3, a fourth 3, then 0,0,0 (one run, not locked)
    localparam logic [1:0] LG_DIN [7] = '{3,3,3,3,0,0,0};
    localparam bit         LG_ED  [7] = '{0,0,1,0,0,0,1};
    localparam logic [1:0] LG_EV  [7] = '{2,2,3,3,3,3,0};
    localparam bit         LG_EL  [7] = '{1,1,1,0,0,0,0};
    localparam bit         LG_EE  [7] = '{0,0,0,1,0,0,0};

    // Phase-misaligned start
    localparam logic [1:0] MS_DIN [11] = '{1,1,2,2,2,3,3,3,0,0,0};
    localparam bit         MS_ED  [11] = '{0,0,0,0,1,0,0,1,0,0,1};
    localparam logic [1:0] MS_EV  [11] = '{0,0,0,0,2,2,2,3,3,3,0};
    localparam bit         MS_EL  [11] = '{0,0,0,0,0,0,0,1,1,1,1};

    // After a reset mid-lock: the old run must not continue, 3 is a fresh +1
    localparam logic [1:0] RR_DIN [6] = '{2,2,2,3,3,3};
    localparam bit         RR_ED  [6] = '{0,0,0,0,0,1};
    localparam logic [1:0] RR_EV  [6] = '{0,0,0,0,0,3};

    // Apply one input cycle; returns 1 time unit after the edge that consumed it.
    task automatic drive(input logic v, input logic [1:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 2'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        obs = {bus.run_done, bus.run_value, bus.locked, bus.err, bus.err_count};
        vectors++;
        if (obs !== 13'd0) begin
            miscompares++;
            $display("FAIL reset: outputs got %b want %b", obs, 13'd0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_clean();
        logic [4:0] obs, exp;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, CL_DIN[i]);
            obs = {bus.run_done, bus.run_value, bus.locked, bus.err};
            exp = {CL_ED[i], CL_EV[i], CL_EL[i], 1'b0};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL clean[%0d] done/val/lock/err: got %b want %b", i, obs, exp);
            end
        end
        vectors++;
        if (bus.err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL clean err_count: got %0d want 0", bus.err_count);
        end
    endtask

    task automatic test_gaps();
        logic [4:0] obs, exp;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, CL_DIN[i]);
            obs = {bus.run_done, bus.run_value, bus.locked, bus.err};
            exp = {CL_ED[i], CL_EV[i], CL_EL[i], 1'b0};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL gaps[%0d] done/val/lock/err: got %b want %b", i, obs, exp);
            end
            for (int g = 0; g < GAP[i]; g++) begin
                // Data on idle cycles is a legal-looking successor that must be ignored.
                drive(1'b0, CL_DIN[i] + 2'd1);
                obs = {bus.run_done, bus.run_value, bus.locked, bus.err};
                exp = {1'b0, CL_EV[i], CL_EL[i], 1'b0};
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL gap_idle[%0d.%0d] done/val/lock/err: got %b want %b", i, g, obs, exp);
                end
            end
        end
    endtask

    task automatic test_short_run();
        logic [4:0] obs, exp;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, SH_DIN[i]);
            obs = {bus.run_done, bus.run_value, bus.locked, bus.err};
            exp = {SH_ED[i], SH_EV[i], SH_EL[i], SH_EE[i]};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL short[%0d] done/val/lock/err: got %b want %b", i, obs, exp);
            end
        end
        vectors++;
        if (bus.err_count !== 8'd1) begin
            miscompares++;
            $display("FAIL short err_count: got %0d want 1", bus.err_count);
        end
    endtask

    // Continues from the locked state left by test_short_run (run of 2 complete).
    task automatic test_long_run();
        logic [4:0] obs, exp;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, LG_DIN[i]);
            obs = {bus.run_done, bus.run_value, bus.locked, bus.err};
            exp = {LG_ED[i], LG_EV[i], LG_EL[i], LG_EE[i]};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL long[%0d] done/val/lock/err: got %b want %b", i, obs, exp);
            end
        end
        vectors++;
        if (bus.err_count !== 8'd2) begin
            miscompares++;
            $display("FAIL long err_count: got %0d want 2", bus.err_count);
        end
    endtask

    task automatic test_misaligned();
        logic [4:0] obs, exp;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, MS_DIN[i]);
            obs = {bus.run_done, bus.run_value, bus.locked, bus.err};
            exp = {MS_ED[i], MS_EV[i], MS_EL[i], 1'b0};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL misaligned[%0d] done/val/lock/err: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_saturation_reset();
        logic [1:0]  p;
        logic [12:0] obs13;
        logic [2:0]  obs3, exp3;
        do_reset();
        p = 2'd0;
        drive(1'b1, p);
        // Each pair: p+1 syncs from HUNT, p+3 breaks the run at rep=1.
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, p + 2'd1);
            drive(1'b1, p + 2'd3);
            p = p + 2'd3;
            if (i == 254 || i == 259) begin
                vectors++;
                if (bus.err_count !== 8'd255 || bus.err !== 1'b1) begin
                    miscompares++;
                    $display("FAIL saturate[%0d] err/err_count: got %b/%0d want 1/255", i, bus.err, bus.err_count);
                end
            end
        end
        // p has returned to 0 here: 0 is not a +1, then 1,1,1,2,2,2 locks.
        drive(1'b1, 2'd0);
        drive(1'b1, 2'd1);
        drive(1'b1, 2'd1);
        drive(1'b1, 2'd1);
        drive(1'b1, 2'd2);
        drive(1'b1, 2'd2);
        drive(1'b1, 2'd2);
        vectors++;
        if (bus.locked !== 1'b1 || bus.run_done !== 1'b1 || bus.err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL relock lock/done/err_count: got %b/%b/%0d want 1/1/255", bus.locked, bus.run_done, bus.err_count);
        end
        // Reset asserted together with a sample that would otherwise be accepted.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 2'd3;
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs13 = {bus.run_done, bus.run_value, bus.locked, bus.err, bus.err_count};
        vectors++;
        if (obs13 !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_mid_lock outputs: got %b want %b", obs13, 13'd0);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, RR_DIN[i]);
            obs3 = {bus.run_done, bus.run_value};
            exp3 = {RR_ED[i], RR_EV[i]};
            vectors++;
            if (obs3 !== exp3 || bus.locked !== 1'b0 || bus.err !== 1'b0) begin
                miscompares++;
                $display("FAIL reacquire[%0d] done/val lock err: got %b %b %b want %b 0 0", i, obs3, bus.locked, bus.err, exp3);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 2'd0;
        test_reset();
        test_clean();
        test_gaps();
        test_short_run();
        test_long_run();
        test_misaligned();
        test_saturation_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
